clock_divider: RTL and testbench

//  - Derives a slow, registered, glitch-free clock-enable/square wave o_clk from the system clock i_clk.
//  - Output period is exactly DIV input cycles.
//  - Also emits a one-cycle strobe o_tick per output period.
//  - Downstream logic should use o_tick as an enable in the i_clk domain.
//  - o_clk is intended for slow external/visual timing (LED scan, sensor polling), not as a fabric clock.

---
 rtl/clock_divider_pkg.sv | 16 +
 rtl/clock_divider_if.sv | 8 +
 rtl/clock_divider_mod_counter.sv | 27 ++
 rtl/clock_divider.sv | 50 +++++
 tb/tb_clock_divider.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/clock_divider_pkg.sv
// Shared clocking helpers: counter width sizing and frequency-to-divisor conversion.
// Instantiators can write DIV as clk_pkg::div_for_hz(1_000) instead of a raw cycle count.
package clk_pkg;

    localparam longint SYS_CLK_HZ = 100_000_000;

    // A one-bit counter is still needed when the modulus is 1 or 2.
    function automatic int clog2_min1(input longint n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int div_for_hz(input longint hz);
        return int'(SYS_CLK_HZ / hz);
    endfunction

endpackage

// File: rtl/clock_divider_if.sv
// Divided-clock output bundle: square wave plus one-cycle strobe per period.
interface clock_divider_if;
    logic o_clk;
    logic o_tick;

    modport master (output o_clk, output o_tick);
    modport slave  (input  o_clk, input  o_tick);
endinterface

// File: rtl/clock_divider_mod_counter.sv
// Wrapping modulo-MOD counter with synchronous active-high reset.
// o_wrap flags the terminal count MOD-1, so the next edge returns to zero.
module mod_counter #(
    parameter int MOD = 2,
    parameter int W   = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    output logic [W-1:0] o_cnt,
    output logic         o_wrap
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    assign o_wrap = (o_cnt == LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_cnt <= '0;
        end else if (o_wrap) begin
            o_cnt <= '0;
        end else begin
            o_cnt <= o_cnt + W'(1);
        end
    end

endmodule

// File: rtl/clock_divider.sv
// Fixed-ratio clock divider: registered square wave of period DIV and a strobe on its rising edge.
// Both outputs come straight from flops, so they are glitch-free.
module clock_divider
    import clk_pkg::*;
#(
    parameter int DIV = 100_000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    clock_divider_if.master bus
);

    localparam int CNT_W = clog2_min1(DIV);
    // (DIV+1)/2 written so it cannot overflow at DIV = 2^31-1.
    localparam logic [CNT_W-1:0] HIGH = CNT_W'((DIV / 2) + (DIV % 2));

    if (DIV < 2) begin : g_bad_div
        $error("clock_divider: DIV must be at least 2");
    end

    logic [CNT_W-1:0] cnt_p0;
    logic             unused_wrap_p0;
    logic             clk_p1;
    logic             tick_p1;

    mod_counter #(
        .MOD (DIV),
        .W   (CNT_W)
    ) u_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_cnt  (cnt_p0),
        .o_wrap (unused_wrap_p0)
    );

    // p0 -> p1: compare the phase count into the output flops
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            clk_p1  <= 1'b0;
            tick_p1 <= 1'b0;
        end else begin
            clk_p1  <= (cnt_p0 < HIGH);
            tick_p1 <= (cnt_p0 == '0);
        end
    end

    assign bus.o_clk  = clk_p1;
    assign bus.o_tick = tick_p1;

endmodule

// File: tb/tb_clock_divider.sv
// Self-checking bench: six dividers on one clock, each compared every cycle against a phase model
// where phase = edges since reset release, o_clk = (phase mod DIV) < ceil(DIV/2), o_tick = (phase mod DIV == 0).
module tb_clock_divider;

    logic       clk = 1'b0;
    logic [5:0] rst = '1;
    logic [5:0] oc;
    logic [5:0] ot;

    always #5 clk = ~clk;

    clock_divider_if b0 ();
    clock_divider_if b1 ();
    clock_divider_if b2 ();
    clock_divider_if b3 ();
    clock_divider_if b4 ();
    clock_divider_if b5 ();

    clock_divider #(.DIV(4))  u0 (.i_clk(clk), .i_rst(rst[0]), .bus(b0));
    clock_divider #(.DIV(5))  u1 (.i_clk(clk), .i_rst(rst[1]), .bus(b1));
    clock_divider #(.DIV(2))  u2 (.i_clk(clk), .i_rst(rst[2]), .bus(b2));
    clock_divider #(.DIV(10)) u3 (.i_clk(clk), .i_rst(rst[3]), .bus(b3));
    clock_divider #(.DIV(8))  u4 (.i_clk(clk), .i_rst(rst[4]), .bus(b4));
    clock_divider             u5 (.i_clk(clk), .i_rst(rst[5]), .bus(b5));

    assign oc = {b5.o_clk, b4.o_clk, b3.o_clk, b2.o_clk, b1.o_clk, b0.o_clk};
    assign ot = {b5.o_tick, b4.o_tick, b3.o_tick, b2.o_tick, b1.o_tick, b0.o_tick};

    longint divs [6] = '{4, 5, 2, 10, 8, 100000};
    longint phase [6];
    bit     seen [6];
    logic   prev_t [6];
    int     n_tests = 0;
    int     n_fail  = 0;

    // Default-DIV instance: measured length of its first high phase.
    int     hi5   = 0;
    bit     fell5 = 1'b0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One rising edge, then check every divider against the phase model using the reset it saw.
    task automatic cycle();
        logic ec, et;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            if (rst[i]) begin
                seen[i]  = 1'b1;
                phase[i] = 0;
                ec = 1'b0;
                et = 1'b0;
            end else begin
                ec = ((phase[i] % divs[i]) < ((divs[i] + 1) / 2));
                et = ((phase[i] % divs[i]) == 0);
                phase[i]++;
            end
            if (seen[i]) begin
                chk_bit($sformatf("u%0d_clk", i), oc[i], ec);
                chk_bit($sformatf("u%0d_tick", i), ot[i], et);
                chk($sformatf("u%0d_clk_x", i), longint'($isunknown(oc[i])), 0);
                chk($sformatf("u%0d_tick_twice", i), longint'(prev_t[i] & ot[i]), 0);
            end
            prev_t[i] = ot[i];
        end
        if (!rst[5] && !fell5) begin
            if (oc[5] === 1'b1) hi5++;
            else if (hi5 > 0) fell5 = 1'b1;
        end
    endtask

    initial begin
        logic pat4 [4];
        int   ticks3, rises3, high3;
        logic pc3;
        int   guard;

        pat4 = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            phase[i]  = 0;
            seen[i]   = 1'b0;
            prev_t[i] = 1'b0;
        end

        // Reset held for three edges: every output must read zero.
        rst = '1;
        repeat (3) cycle();
        chk("reset_clk", longint'(oc), 0);
        chk("reset_tick", longint'(ot), 0);

        // Release; DIV=10 statistics over 1000 cycles, DIV=8 reset during cycles 5 and 6.
        rst    = '0;
        ticks3 = 0;
        rises3 = 0;
        high3  = 0;
        pc3    = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (c == 5) rst[4] = 1'b1;
            if (c == 7) rst[4] = 1'b0;
            cycle();
            if (c < 8) chk_bit($sformatf("div4_pattern_%0d", c), oc[0], pat4[c % 4]);
            if (c == 7) begin
                chk_bit("div8_release_clk", oc[4], 1'b1);
                chk_bit("div8_release_tick", ot[4], 1'b1);
            end
            if (ot[3] === 1'b1) ticks3++;
            if (oc[3] === 1'b1 && pc3 === 1'b0) rises3++;
            if (oc[3] === 1'b1) high3++;
            pc3 = oc[3];
        end
        chk("div10_ticks", ticks3, 100);
        chk("div10_rises", rises3, 100);
        chk("div10_high_cycles", high3, 500);

        // Random reset pulses on the small dividers; the default one keeps running.
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 5; i++) rst[i] = ($urandom_range(0, 15) == 0);
            cycle();
        end
        rst = '0;
        repeat (20) cycle();

        // Default DIV=100_000: high phase must last exactly 50_000 cycles.
        guard = 0;
        while (!fell5 && guard < 60000) begin
            cycle();
            guard++;
        end
        chk("default_fell", longint'(fell5), 1);
        chk("default_high_cycles", hi5, 50000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
